// File: rtl/y86_seq_ctrl_if.sv
// Handshake bundle between the Y86-64 stage sequencer and its fetch unit,
// data memory and stage logic.
interface y86_seq_ctrl_if;
    logic        fetch_done;
    logic [3:0]  icode;
    logic [63:0] valP;
    logic [63:0] valC;
    logic [63:0] valM;
    logic        cnd;
    logic        mem_ready;
    logic        dmem_error;
    logic        fetch_en;
    logic        decode_en;
    logic        exec_en;
    logic        mem_en;
    logic        wb_en;
    logic        pcupd_en;

    modport master (
        input  fetch_done, icode, valP, valC, valM, cnd, mem_ready, dmem_error,
        output fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en
    );

    modport slave (
        output fetch_done, icode, valP, valC, valM, cnd, mem_ready, dmem_error,
        input  fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en
    );
endinterface

// File: rtl/y86_seq_ctrl.sv
// Sequential Y86-64 stage sequencer: owns the PC, steps one stage per state,
// waits on fetch/memory handshakes and reports Y86 status.
module y86_seq_ctrl #(
    parameter int IMEM_BITS = 640,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [63:0]          start_pc,
    y86_seq_ctrl_if.master       bus,
    output logic [63:0]          pc,
    output logic [2:0]           stat,
    output logic                 busy,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt
);
    localparam int          WW       = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);
    localparam logic [63:0] IMEM_LIM = 64'(IMEM_BITS);
    localparam logic [2:0]  ST_AOK   = 3'd1;
    localparam logic [2:0]  ST_HLT   = 3'd2;
    localparam logic [2:0]  ST_ADR   = 3'd3;
    localparam logic [2:0]  ST_INS   = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
        S_WRITEBACK, S_PCUPD, S_HALT, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [2:0]    stat_q, stat_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [31:0]   ins_q, ins_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [3:0]    icode_q, icode_d;
    logic [63:0]   valp_q, valp_d;
    logic [63:0]   valc_q, valc_d;
    logic [63:0]   valm_q, valm_d;
    logic          cnd_q, cnd_d;
    logic [63:0]   npc_s;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    function automatic logic is_mem_f(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_f = 1'b1;
            default:                            is_mem_f = 1'b0;
        endcase
    endfunction

    function automatic logic is_busy_f(input state_t st);
        case (st)
            S_IDLE, S_HALT, S_FAULT: is_busy_f = 1'b0;
            default:                 is_busy_f = 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] next_pc_f(input logic [3:0] ic, input logic c,
                                              input logic [63:0] p, input logic [63:0] k,
                                              input logic [63:0] m);
        case (ic)
            4'h7:    next_pc_f = c ? k : p;
            4'h8:    next_pc_f = k;
            4'h9:    next_pc_f = m;
            default: next_pc_f = p;
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= 64'd0;
            stat_q  <= ST_AOK;
            cyc_q   <= 32'd0;
            ins_q   <= 32'd0;
            wait_q  <= '0;
            icode_q <= 4'd0;
            valp_q  <= 64'd0;
            valc_q  <= 64'd0;
            valm_q  <= 64'd0;
            cnd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            wait_q  <= wait_d;
            icode_q <= icode_d;
            valp_q  <= valp_d;
            valc_q  <= valc_d;
            valm_q  <= valm_d;
            cnd_q   <= cnd_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        ins_d   = ins_q;
        wait_d  = wait_q;
        icode_d = icode_q;
        valp_d  = valp_q;
        valc_d  = valc_q;
        valm_d  = valm_q;
        cnd_d   = cnd_q;
        npc_s   = next_pc_f(icode_q, cnd_q, valp_q, valc_q, valm_q);
        if (is_busy_f(state_q)) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end

        case (state_q)
            S_IDLE, S_HALT, S_FAULT: begin
                if (start) begin
                    pc_d   = start_pc;
                    stat_d = ST_AOK;
                    cyc_d  = 32'd0;
                    ins_d  = 32'd0;
                    if (start_pc >= IMEM_LIM) begin
                        state_d = S_FAULT;
                        stat_d  = ST_ADR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                if (bus.fetch_done) begin
                    icode_d = bus.icode;
                    valp_d  = bus.valP;
                    valc_d  = bus.valC;
                    if (bus.icode == 4'h0) begin
                        state_d = S_HALT;
                        stat_d  = ST_HLT;
                    end else if (bus.icode > 4'hB) begin
                        state_d = S_FAULT;
                        stat_d  = ST_INS;
                    end else begin
                        state_d = S_DECODE;
                    end
                end else if (wait_q == TO_LAST) begin
                    state_d = S_FAULT;
                    stat_d  = ST_ADR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                cnd_d   = bus.cnd;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!is_mem_f(icode_q)) begin
                    state_d = S_WRITEBACK;
                end else if (bus.mem_ready) begin
                    valm_d = bus.valM;
                    if (bus.dmem_error) begin
                        state_d = S_FAULT;
                        stat_d  = ST_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == TO_LAST) begin
                    state_d = S_FAULT;
                    stat_d  = ST_ADR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                pc_d  = npc_s;
                ins_d = ins_q + 32'd1;
                if (npc_s >= IMEM_LIM) begin
                    state_d = S_FAULT;
                    stat_d  = ST_ADR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // a restart re-arms the wait counter even when FAULT re-enters FAULT
        if ((state_d != state_q) || (!is_busy_f(state_q) && start)) begin
            wait_d = '0;
        end else begin
            wait_d = wait_d;
        end
    end

    // Moore stage enables and status outputs
    always_comb begin
        bus.fetch_en  = 1'b0;
        bus.decode_en = 1'b0;
        bus.exec_en   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.wb_en     = 1'b0;
        bus.pcupd_en  = 1'b0;
        case (state_q)
            S_FETCH:     bus.fetch_en  = 1'b1;
            S_DECODE:    bus.decode_en = 1'b1;
            S_EXECUTE:   bus.exec_en   = 1'b1;
            S_MEMORY:    bus.mem_en    = is_mem_f(icode_q);
            S_WRITEBACK: bus.wb_en     = 1'b1;
            S_PCUPD:     bus.pcupd_en  = 1'b1;
            default:     bus.fetch_en  = 1'b0;
        endcase
        busy      = is_busy_f(state_q);
        pc        = pc_q;
        stat      = stat_q;
        cycle_cnt = cyc_q;
        instr_cnt = ins_q;
    end
endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed testbench for the Y86-64 stage sequencer.
module tb_y86_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] start_pc = 64'd0;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    logic        fetch_done_r = 1'b0;
    logic [3:0]  icode_r = 4'd0;
    logic        auto_p = 1'b0;
    logic [63:0] valp_r = 64'd0;
    logic [63:0] valc_r = 64'd0;
    logic [63:0] valm_r = 64'd0;
    logic        cnd_r = 1'b0;
    logic        mem_ready_r = 1'b0;
    logic        dmem_error_r = 1'b0;
    logic [5:0]  en;

    int n_cmp = 0;
    int n_bad = 0;

    y86_seq_ctrl_if ifc ();

    assign ifc.fetch_done = fetch_done_r;
    assign ifc.icode      = icode_r;
    assign ifc.valP       = auto_p ? (pc + 64'd8) : valp_r;
    assign ifc.valC       = valc_r;
    assign ifc.valM       = valm_r;
    assign ifc.cnd        = cnd_r;
    assign ifc.mem_ready  = mem_ready_r;
    assign ifc.dmem_error = dmem_error_r;
    assign en = {ifc.fetch_en, ifc.decode_en, ifc.exec_en, ifc.mem_en, ifc.wb_en, ifc.pcupd_en};

    y86_seq_ctrl #(.IMEM_BITS(640), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_pc  (start_pc),
        .bus       (ifc),
        .pc        (pc),
        .stat      (stat),
        .busy      (busy),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // pulse start and return at the negedge of the first cycle after it
    task automatic start_at(input logic [63:0] addr);
        start = 1'b1;
        start_pc = addr;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        step(3);
        n_cmp++; if (pc !== 64'd0) begin n_bad++; $display("FAIL reset_pc got %0d exp 0", pc); end
        n_cmp++; if (stat !== 3'd1) begin n_bad++; $display("FAIL reset_stat got %0d exp 1", stat); end
        n_cmp++; if ({busy, en} !== 7'd0) begin n_bad++; $display("FAIL reset_busy_en got %b exp 0", {busy, en}); end
        n_cmp++; if ({cycle_cnt, instr_cnt} !== 64'd0) begin n_bad++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", cycle_cnt, instr_cnt); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_nop_stream;
        logic [5:0] exp_en [6];
        exp_en[0] = 6'b100000; exp_en[1] = 6'b010000; exp_en[2] = 6'b001000;
        exp_en[3] = 6'b000000; exp_en[4] = 6'b000010; exp_en[5] = 6'b000001;
        auto_p = 1'b1;
        fetch_done_r = 1'b1;
        icode_r = 4'h1;
        start_at(64'd0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (en !== exp_en[i]) begin n_bad++; $display("FAIL nop_stage%0d got %b exp %b", i, en, exp_en[i]); end
            step(1);
        end
        n_cmp++; if (pc !== 64'd8) begin n_bad++; $display("FAIL nop_pc8 got %0d exp 8", pc); end
        step(12);
        n_cmp++; if (pc !== 64'd24) begin n_bad++; $display("FAIL nop_pc24 got %0d exp 24", pc); end
        n_cmp++; if (instr_cnt !== 32'd3) begin n_bad++; $display("FAIL nop_instr got %0d exp 3", instr_cnt); end
        n_cmp++; if (cycle_cnt !== 32'd18) begin n_bad++; $display("FAIL nop_cycles got %0d exp 18", cycle_cnt); end
        auto_p = 1'b0;
    endtask

    task automatic test_halt;
        icode_r = 4'h0;
        step(1);
        n_cmp++; if (stat !== 3'd2) begin n_bad++; $display("FAIL halt_stat got %0d exp 2", stat); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL halt_busy got %b exp 0", busy); end
        step(2);
        n_cmp++; if (pc !== 64'd24 || instr_cnt !== 32'd3 || cycle_cnt !== 32'd19) begin
            n_bad++; $display("FAIL halt_hold got pc=%0d ic=%0d cc=%0d exp 24/3/19", pc, instr_cnt, cycle_cnt);
        end
    endtask

    task automatic test_branches;
        icode_r = 4'h7; valp_r = 64'd72; valc_r = 64'd200; cnd_r = 1'b1;
        mem_ready_r = 1'b1; dmem_error_r = 1'b0;
        start_at(64'd64);
        step(6);
        n_cmp++; if (pc !== 64'd200) begin n_bad++; $display("FAIL jxx_taken got %0d exp 200", pc); end
        cnd_r = 1'b0;
        step(6);
        n_cmp++; if (pc !== 64'd72) begin n_bad++; $display("FAIL jxx_not_taken got %0d exp 72", pc); end
        icode_r = 4'h8; valc_r = 64'd320;
        step(6);
        n_cmp++; if (pc !== 64'd320) begin n_bad++; $display("FAIL call_pc got %0d exp 320", pc); end
        icode_r = 4'h9; valm_r = 64'd48;
        step(3);
        n_cmp++; if (en !== 6'b000100) begin n_bad++; $display("FAIL ret_mem_en got %b exp 000100", en); end
        step(3);
        n_cmp++; if (pc !== 64'd48 || instr_cnt !== 32'd4) begin n_bad++; $display("FAIL ret_pc got %0d/%0d exp 48/4", pc, instr_cnt); end
        icode_r = 4'h0;
        step(1);
    endtask

    task automatic test_mem_wait;
        icode_r = 4'h5; valp_r = 64'd10; mem_ready_r = 1'b0; dmem_error_r = 1'b0;
        start_at(64'd0);
        step(3);
        step(3);
        n_cmp++; if (en !== 6'b000100 || pc !== 64'd0) begin n_bad++; $display("FAIL mem_waiting got en=%b pc=%0d exp 000100/0", en, pc); end
        mem_ready_r = 1'b1;
        step(3);
        n_cmp++; if (pc !== 64'd10 || cycle_cnt !== 32'd9) begin n_bad++; $display("FAIL mem_latency got pc=%0d cc=%0d exp 10/9", pc, cycle_cnt); end
        mem_ready_r = 1'b0; valp_r = 64'd18;
        step(6);
        mem_ready_r = 1'b1; dmem_error_r = 1'b1;
        step(1);
        n_cmp++; if (stat !== 3'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL dmem_err got stat=%0d busy=%b exp 3/0", stat, busy); end
        n_cmp++; if (pc !== 64'd10 || instr_cnt !== 32'd1) begin n_bad++; $display("FAIL dmem_err_pc got %0d/%0d exp 10/1", pc, instr_cnt); end
        mem_ready_r = 1'b0; dmem_error_r = 1'b0;
    endtask

    task automatic test_invalid;
        icode_r = 4'hC;
        start_at(64'd16);
        n_cmp++; if (stat !== 3'd1 || pc !== 64'd16 || instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            n_bad++; $display("FAIL restart got stat=%0d pc=%0d ic=%0d cc=%0d exp 1/16/0/0", stat, pc, instr_cnt, cycle_cnt);
        end
        step(1);
        n_cmp++; if (stat !== 3'd4 || busy !== 1'b0) begin n_bad++; $display("FAIL ins_fault got stat=%0d busy=%b exp 4/0", stat, busy); end
    endtask

    task automatic test_timeout;
        fetch_done_r = 1'b0; icode_r = 4'h1; valp_r = 64'd8;
        start_at(64'd0);
        step(15);
        n_cmp++; if (en !== 6'b100000) begin n_bad++; $display("FAIL to_before got en=%b exp 100000", en); end
        step(1);
        n_cmp++; if (stat !== 3'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL to_fault got stat=%0d busy=%b exp 3/0", stat, busy); end
        start_at(64'd0);
        step(15);
        fetch_done_r = 1'b1;
        step(1);
        n_cmp++; if (en !== 6'b010000 || stat !== 3'd1) begin n_bad++; $display("FAIL to_handshake_wins got en=%b stat=%0d exp 010000/1", en, stat); end
        step(5);
        icode_r = 4'h0;
        step(1);
    endtask

    task automatic test_pc_range;
        icode_r = 4'h1; fetch_done_r = 1'b1; valp_r = 64'd632;
        start_at(64'd0);
        step(6);
        n_cmp++; if (pc !== 64'd632 || en !== 6'b100000) begin n_bad++; $display("FAIL pc_632 got pc=%0d en=%b exp 632/100000", pc, en); end
        valp_r = 64'd640;
        step(6);
        n_cmp++; if (stat !== 3'd3 || pc !== 64'd640 || busy !== 1'b0) begin
            n_bad++; $display("FAIL pc_640 got stat=%0d pc=%0d busy=%b exp 3/640/0", stat, pc, busy);
        end
        start_at(64'd640);
        n_cmp++; if (stat !== 3'd3 || busy !== 1'b0 || pc !== 64'd640) begin
            n_bad++; $display("FAIL start_640 got stat=%0d busy=%b pc=%0d exp 3/0/640", stat, busy, pc);
        end
    endtask

    task automatic test_ignored_start;
        fetch_done_r = 1'b0;
        start_at(64'd32);
        start_at(64'd400);
        n_cmp++; if (pc !== 64'd32 || en !== 6'b100000 || cycle_cnt !== 32'd1) begin
            n_bad++; $display("FAIL ignored_start got pc=%0d en=%b cc=%0d exp 32/100000/1", pc, en, cycle_cnt);
        end
    endtask

    task automatic test_async_reset;
        fetch_done_r = 1'b1; icode_r = 4'h5; mem_ready_r = 1'b0;
        step(3);
        n_cmp++; if (en !== 6'b000100) begin n_bad++; $display("FAIL ar_in_mem got en=%b exp 000100", en); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 64'd0 || stat !== 3'd1 || busy !== 1'b0 || en !== 6'd0 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            n_bad++; $display("FAIL async_reset got pc=%0d stat=%0d busy=%b en=%b cc=%0d", pc, stat, busy, en, cycle_cnt);
        end
        step(1);
        rst_n = 1'b1;
        step(2);
        n_cmp++; if (busy !== 1'b0 || pc !== 64'd0) begin n_bad++; $display("FAIL ar_idle got busy=%b pc=%0d exp 0/0", busy, pc); end
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_halt();
        test_branches();
        test_mem_wait();
        test_invalid();
        test_timeout();
        test_pc_range();
        test_ignored_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
